square_iterative_hs: RTL and testbench
======================================

// Module: square_iterative_hs
// PURPOSE
//  - Fixed-point squarer (y = x*x): the inverse direction of the piecewise square-root datapath.
//  - Squares a signed Q4.11 operand with a sequential shift-add multiplier behind valid/ready handshakes.
//  - Reconstructs x from sqrt(x) for accuracy checks; also feeds the variance/energy paths of Level-3 blocks.
// PARAMETERS
//  - BITSIZE  16  operand/result width, two's complement
//  - FRAC     11  fractional bits (Q4.11 at the default width); must satisfy 1 <= FRAC < BITSIZE
// PORTS
//  - clk        in   1        clock, rising edge
//  - reset      in   1        asynchronous, active-high reset
//  - in_valid   in   1        data_in is valid
//  - in_ready   out  1        block can accept an operand
//  - data_in    in   BITSIZE  signed operand x
//  - out_valid  out  1        data_out/overflow are valid
//  - out_ready  in   1        downstream consumes the result
//  - data_out   out  BITSIZE  x*x in the same Q format, saturated
//  - overflow   out  1        1 = true square exceeded the maximum and was clamped
// BEHAVIOUR
//  - Reset: state = IDLE. Registered outputs: out_valid=0, data_out=0, overflow=0.
//    Internal mag, acc and cnt clear to 0. in_ready reads 1 (IDLE), but inputs are ignored while reset=1.
//  - Reset mid-operation discards the in-flight operand; no partial result is ever presented.
//  - FSM states and transitions:
//    - IDLE: in_ready=1. On in_valid&in_ready: mag <= |data_in| as BITSIZE-bit unsigned
//      (0x8000 -> 32768), acc <= 0, cnt <= 0, go to CALC.
//    - CALC: in_ready=0. One multiplier bit per cycle: if mag[cnt], acc <= acc + (mag << cnt).
//      acc is 2*BITSIZE bits wide. cnt increments; after bit BITSIZE-1 go to NORM.
//    - NORM: r = acc >> FRAC (see CONFIGURATION for rounding).
//      If r > 2^(BITSIZE-1)-1: data_out <= 0x7FFF (max positive), overflow <= 1.
//      Else: data_out <= r[BITSIZE-1:0], overflow <= 0. Set out_valid <= 1, go to DONE.
//    - DONE: out_valid=1; data_out and overflow are held stable.
//      On out_ready: out_valid <= 0, go to IDLE.
//  - Latency: out_valid rises on the BITSIZE+1-th rising edge after the accepting edge (17 at default).
//  - Throughput: at most one operand per BITSIZE+3 cycles.
//    in_ready is 0 in the cycle of the out handshake; there is no accept in DONE.
//  - data_in is sampled only at acceptance; later changes have no effect.
//  - in_valid while in_ready=0 is ignored. The upstream holds the operand until accepted.
//  - The result is always >= 0; the sign of data_in never affects data_out.
//  - After an out handshake, data_out/overflow keep their last values until the next NORM.
//  - out_ready while out_valid=0 has no effect.
// CONFIGURATION
//  - SQUARE_ROUND_EN defined: round-half-up, r = (acc + 2^(FRAC-1)) >> FRAC.
//    Saturation is checked after rounding.
//  - SQUARE_ROUND_EN undefined: truncate, r = acc >> FRAC. This is the default, bit-matching fixed_point_multiply.
// TESTING
//  - 0x0800 (1.0) -> data_out 0x0800, overflow 0; out_valid exactly 17 cycles after accept.
//  - 0xF400 (-1.5) -> 0x1200 (2.25), overflow 0. Also 0x1000 (2.0) -> 0x2000 (4.0).
//  - 0x2000 (4.0) -> 0x7FFF, overflow 1. 0x8000 (-16.0) -> 0x7FFF, overflow 1.
//    0x1FFF -> 0x7FF8, overflow 0.
//  - 0x002D -> 0x0000 without SQUARE_ROUND_EN, 0x0001 with it. 0x0001 -> 0x0000 in both builds.
//  - Backpressure: hold out_ready=0 for 10 cycles after out_valid.
//    Required: data_out stable, in_ready=0, and a second in_valid is not accepted until after the out handshake.
//  - Assert reset at cycle 8 of CALC -> out_valid/data_out/overflow = 0 immediately.
//    A fresh operand 0x0C00 after release -> 0x1200.

Source files
------------

// File: rtl/square_iterative_hs.sv
// square_iterative_hs: fixed-point squarer y = x*x on a signed Q(BITSIZE-FRAC).FRAC operand,
// built as a sequential shift-add multiplier that retires one multiplier bit per clock.
// The result keeps the operand's Q format and saturates to the maximum positive value.
//
// Optional build macro: SQUARE_ROUND_EN
//   defined   -> round-half-up before the saturation check
//   undefined -> truncate (default)
//
// Ports
//   clk        in   1        clock, rising edge
//   reset      in   1        asynchronous, active-high reset
//   in_valid   in   1        data_in is valid
//   in_ready   out  1        block can accept an operand (high only in IDLE)
//   data_in    in   BITSIZE  signed operand x
//   out_valid  out  1        data_out/overflow are valid
//   out_ready  in   1        downstream consumes the result
//   data_out   out  BITSIZE  x*x in the same Q format, saturated
//   overflow   out  1        true square exceeded the maximum and was clamped
module square_iterative_hs #(
   parameter int unsigned BITSIZE = 16,
   parameter int unsigned FRAC    = 11
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [BITSIZE-1:0] data_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [BITSIZE-1:0] data_out,
   output logic               overflow
);

   localparam int unsigned ACC_W = 2 * BITSIZE;
   // One spare bit so the rounding increment can never wrap the accumulator.
   localparam int unsigned RND_W = ACC_W + 1;
   localparam int unsigned CNT_W = (BITSIZE > 1) ? $clog2(BITSIZE) : 1;

   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(BITSIZE - 1);
   localparam logic [RND_W-1:0]   SAT_MAX  = {{(RND_W - BITSIZE + 1){1'b0}}, {(BITSIZE - 1){1'b1}}};
   localparam logic [BITSIZE-1:0] OUT_MAX  = {1'b0, {(BITSIZE - 1){1'b1}}};
`ifdef SQUARE_ROUND_EN
   localparam logic [RND_W-1:0]   HALF_LSB = RND_W'(1) << (FRAC - 1);
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      NORM = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [BITSIZE-1:0] mag_q, mag_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               out_valid_q, out_valid_d;
   logic [BITSIZE-1:0] data_out_q, data_out_d;
   logic               overflow_q, overflow_d;

   logic [BITSIZE-1:0] abs_in_c;
   logic [RND_W-1:0]   scaled_c;

   // Magnitude as unsigned: the most negative code maps to 2^(BITSIZE-1).
   assign abs_in_c = data_in[BITSIZE-1] ? BITSIZE'(~data_in + 1'b1) : data_in;

   // Drop the extra FRAC fraction bits produced by the product.
`ifdef SQUARE_ROUND_EN
   assign scaled_c = (RND_W'(acc_q) + HALF_LSB) >> FRAC;
`else
   assign scaled_c = RND_W'(acc_q) >> FRAC;
`endif

   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign data_out  = data_out_q;
   assign overflow  = overflow_q;

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         mag_q       <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         data_out_q  <= '0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         mag_q       <= mag_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         data_out_q  <= data_out_d;
         overflow_q  <= overflow_d;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d     = state_q;
      mag_d       = mag_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      data_out_d  = data_out_q;
      overflow_d  = overflow_q;

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               mag_d   = abs_in_c;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            // Add the partial product for multiplier bit cnt.
            if (mag_q[cnt_q]) begin
               acc_d = acc_q + (ACC_W'(mag_q) << cnt_q);
            end
            cnt_d = CNT_W'(cnt_q + 1'b1);
            if (cnt_q == CNT_LAST) begin
               state_d = NORM;
            end
         end
         NORM: begin
            if (scaled_c > SAT_MAX) begin
               data_out_d = OUT_MAX;
               overflow_d = 1'b1;
            end else begin
               data_out_d = scaled_c[BITSIZE-1:0];
               overflow_d = 1'b0;
            end
            out_valid_d = 1'b1;
            state_d     = DONE;
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_square_iterative_hs.sv
// Bench for square_iterative_hs: directed vector table, handshake corner cases and
// randomized operands checked against an integer-arithmetic reference model.
module tb_square_iterative_hs;

   localparam int unsigned W    = 16;
   localparam int unsigned FRAC = 11;
   localparam int          LAT  = 17;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] data_in;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] data_out;
   logic         overflow;

   int n_tests = 0;
   int n_fail  = 0;

   square_iterative_hs #(.BITSIZE(W), .FRAC(FRAC)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic         ovf;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: exact square with plain integer arithmetic, then scale and clamp.
   task automatic model(input logic [W-1:0] x, output logic [W-1:0] y, output logic ovf);
      longint v;
      longint p;
      v = longint'($signed(x));
      p = v * v;
`ifdef SQUARE_ROUND_EN
      p = p + (longint'(1) << (FRAC - 1));
`endif
      p = p / (longint'(1) << FRAC);
      if (p > 32767) begin
         y   = 16'h7FFF;
         ovf = 1'b1;
      end else begin
         y   = W'(p);
         ovf = 1'b0;
      end
   endtask

   // Present x, wait for acceptance, then count edges until out_valid (bounded).
   task automatic start_and_wait(input logic [W-1:0] x, output int lat);
      int k;
      in_valid = 1'b1;
      data_in  = x;
      k = 0;
      while (!in_ready && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      if (k >= 100) check("accept_timeout", 32'(k), 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      data_in  = W'($urandom);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic handshake(input int delay);
      repeat (delay) begin
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("out_valid_drop", 32'(out_valid), 32'd0);
   endtask

   vec_t vecs[10];

   initial begin
      int           lat;
      logic [W-1:0] ey;
      logic         eo;
      logic [W-1:0] rx;

      vecs[0] = '{16'h0800, 16'h0800, 1'b0};
      vecs[1] = '{16'hF400, 16'h1200, 1'b0};
      vecs[2] = '{16'h1000, 16'h2000, 1'b0};
      vecs[3] = '{16'h2000, 16'h7FFF, 1'b1};
      vecs[4] = '{16'h8000, 16'h7FFF, 1'b1};
      vecs[5] = '{16'h1FFF, 16'h7FF8, 1'b0};
`ifdef SQUARE_ROUND_EN
      vecs[6] = '{16'h002D, 16'h0001, 1'b0};
`else
      vecs[6] = '{16'h002D, 16'h0000, 1'b0};
`endif
      vecs[7] = '{16'h0001, 16'h0000, 1'b0};
      vecs[8] = '{16'h0000, 16'h0000, 1'b0};
      vecs[9] = '{16'hE000, 16'h7FFF, 1'b1};

      reset     = 1'b1;
      in_valid  = 1'b1;
      data_in   = 16'h1234;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_data_out",  32'(data_out),  32'd0);
      check("rst_overflow",  32'(overflow),  32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd1);
      in_valid = 1'b0;
      reset    = 1'b0;
      @(posedge clk); #1;

      // Directed table.
      for (int i = 0; i < 10; i++) begin
         start_and_wait(vecs[i].x, lat);
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
         check($sformatf("vec%0d_data", i), 32'(data_out), 32'(vecs[i].y));
         check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
         handshake(i % 3);
         check($sformatf("vec%0d_hold_data", i), 32'(data_out), 32'(vecs[i].y));
      end

      // Backpressure: result held, no second accept until the out handshake.
      start_and_wait(16'h1000, lat);
      check("bp_latency", 32'(lat), 32'(LAT));
      in_valid = 1'b1;
      data_in  = 16'h0800;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         check($sformatf("bp_data_c%0d", c), 32'(data_out), 32'h2000);
         check($sformatf("bp_in_ready_c%0d", c), 32'(in_ready), 32'd0);
         check($sformatf("bp_out_valid_c%0d", c), 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp_after_hs_valid", 32'(out_valid), 32'd0);
      check("bp_after_hs_ready", 32'(in_ready), 32'd1);
      start_and_wait(16'h0800, lat);
      check("bp_second_latency", 32'(lat), 32'(LAT));
      check("bp_second_data", 32'(data_out), 32'h0800);
      handshake(0);

      // Reset in the middle of CALC.
      in_valid = 1'b1;
      data_in  = 16'h1FFF;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_data_out",  32'(data_out),  32'd0);
      check("midrst_overflow",  32'(overflow),  32'd0);
      check("midrst_in_ready",  32'(in_ready),  32'd1);
      @(posedge clk); #1;
      reset = 1'b0;
      start_and_wait(16'h0C00, lat);
      check("postrst_latency", 32'(lat), 32'(LAT));
      check("postrst_data", 32'(data_out), 32'h1200);
      check("postrst_ovf",  32'(overflow), 32'd0);
      handshake(1);

      // Randomized operands against the reference model.
      for (int i = 0; i < 150; i++) begin
         rx = W'($urandom);
         if (i % 4 == 0) rx = W'($urandom_range(0, 16'h3FFF)) ^ {W{rx[0]}};
         model(rx, ey, eo);
         start_and_wait(rx, lat);
         check($sformatf("rnd%0d_latency x=%h", i, rx), 32'(lat), 32'(LAT));
         check($sformatf("rnd%0d_data x=%h", i, rx), 32'(data_out), 32'(ey));
         check($sformatf("rnd%0d_ovf x=%h", i, rx), 32'(overflow), 32'(eo));
         handshake(int'($urandom_range(0, 3)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
